dmem_store_buffer: RTL

- Responder end of the CPU data-memory bus. Sits between the pipeline's M-stage request signals (memwrite, address, write data, read enable) and a word-addressed data RAM.
- Stores are posted into a small FIFO and return immediately. A drain FSM retires them to the RAM with a fixed write latency.
- Loads answer in the same cycle, with forwarding from the buffer. A stall is returned only when a store arrives at a full buffer that is not popping.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_store_buffer_fifo.sv | 67 ++++++
 rtl/dmem_store_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory store buffer.
package dmem_pkg;

    localparam int DMEM_AW      = 6;
    localparam int DMEM_DEPTH   = 4;
    localparam int DMEM_WR_WAIT = 2;

    // One posted store: word index plus write data.
    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [31:0]        data;
    } sb_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// Store-buffer storage: circular FIFO of posted stores with a youngest-match
// forwarding lookup across all valid entries.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = DMEM_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  sb_entry_t          push_entry,
    output sb_entry_t          head,
    output logic [PW:0]        count,
    input  logic [DMEM_AW-1:0] lookup_addr,
    output logic               hit,
    output logic [31:0]        hit_data
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

    sb_entry_t     mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] slot;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_ONE;
            if (pop)  head_ptr <= head_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_entry;
    end

    assign head = mem[head_ptr];

    // Walk oldest to youngest so the last match found is the youngest one
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_ptr + PW'(i);
            if (((PW + 1)'(i) < count) && (mem[slot].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = mem[slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Responder end of the CPU data-memory bus: posts stores into a small FIFO,
// drains them to a word-addressed RAM with a fixed write latency, and answers
// loads combinationally with forwarding from the buffer.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int  AW      = DMEM_AW,
    parameter int  DEPTH   = DMEM_DEPTH,
    parameter int  WR_WAIT = DMEM_WR_WAIT,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [31:0]   a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          stall,
    output logic          empty,
    output logic [CW-1:0] count
);

    // The entry type carries a DMEM_AW-wide index, so AW tracks the package.
    localparam int            WW        = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WR_WAIT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_LEFT  = CW'(1);

    drain_state_t  state;
    drain_state_t  state_nx;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_nx;
    logic [31:0]   ram [2**AW];
    logic [AW-1:0] widx;
    logic          pop_now;
    logic          push;
    sb_entry_t     push_entry;
    sb_entry_t     head;
    logic          hit;
    logic [31:0]   hit_data;
    logic          unused_abits;

    // Only the word index selects a RAM location; upper bits alias.
    assign widx         = a[AW+1:2];
    assign unused_abits = ^{a[31:AW+2], a[1:0]};

    // A pop frees a slot on the same edge, so a full buffer only stalls
    // when it is not retiring an entry this cycle.
    assign pop_now    = (state == WRITE) && (wcnt == '0);
    assign stall      = memwrite && (count == FULL) && !pop_now;
    assign push       = memwrite && !stall;
    assign push_entry = '{addr: widx, data: wd};
    assign empty      = (count == '0) && (state == IDLE);

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop_now),
        .push_entry  (push_entry),
        .head        (head),
        .count       (count),
        .lookup_addr (widx),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // Drain FSM state and write-port wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Start draining when entries are queued; retire one entry each time the
    // counter expires and keep going while anything remains after that edge.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = WRITE;
                    wcnt_nx  = WAIT_LOAD;
                end
            end
            WRITE: begin
                if (wcnt != '0) begin
                    wcnt_nx = wcnt - WAIT_ONE;
                end else if ((count > ONE_LEFT) || push) begin
                    state_nx = WRITE;
                    wcnt_nx  = WAIT_LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                wcnt_nx  = '0;
            end
        endcase
    end

    // RAM write port: the head entry lands in the array on its pop edge
    always_ff @(posedge clk) begin
        if (pop_now) ram[head.addr] <= head.data;
    end

    // Load data: youngest buffered match first, RAM otherwise; a cycle that
    // also carries a store is treated as a store and returns zero
    always_comb begin
        rd = '0;
        if (memread && !memwrite) begin
            rd = hit ? hit_data : ram[widx];
        end
    end

endmodule
